// File: rtl/warships_pkg.sv
// warships_pkg: shared board types and constants for the warships board logic.
//   cell_t         : 2-bit board cell encoding
//   arb_state_t    : board_write_arb FSM states
//   grant_t        : last client winner for round-robin
//   coord_on_grid(): true when (x,y) lies inside an x_size by y_size board
package warships_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_MISS  = 2'b10,
    CELL_HIT   = 2'b11
  } cell_t;

  localparam int unsigned BOARD_X_SIZE = 12;
  localparam int unsigned BOARD_Y_SIZE = 12;
  localparam int unsigned COORD_W      = 4;
  localparam int unsigned BOARD_ADDR_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CLEAR,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    GNT_PLACE,
    GNT_SHOT
  } grant_t;

  function automatic logic coord_on_grid(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y,
                                         input int unsigned        x_size,
                                         input int unsigned        y_size);
    return (32'(x) < x_size) && (32'(y) < y_size);
  endfunction

endpackage

// File: rtl/board_clear_seq.sv
// board_clear_seq: x/y sweep counter for the board clear sequence.
// Walks y=0..Y_SIZE-1 with x=0..X_SIZE-1 as the inner loop, wrapping to (0,0)
// after the final cell.
//   clk   : control clock
//   rst   : asynchronous active-low reset, counter returns to (0,0)
//   start : restart the sweep at (0,0)
//   step  : advance to the next cell
//   x, y  : current cell
//   last  : current cell is the final one (X_SIZE-1, Y_SIZE-1)
module board_clear_seq
  import warships_pkg::*;
#(
  parameter int unsigned X_SIZE = BOARD_X_SIZE,
  parameter int unsigned Y_SIZE = BOARD_Y_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(Y_SIZE - 1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_x_wrap;
  logic               w_y_wrap;

  assign w_x_wrap = (r_x == X_MAX);
  assign w_y_wrap = (r_y == Y_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (step) begin
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= w_y_wrap ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = w_x_wrap & w_y_wrap;

endmodule

// File: rtl/board_write_arb.sv
// board_write_arb: owns the write port of one board_mem instance and shares it
// between an internal clear sweep and two clients (placement, shot).
// Clear has priority; clients are served round-robin in IDLE. Off-grid client
// coordinates are acknowledged with *_err=1 and no write. All outputs registered.
//   clk, rst (async, active-low)
//   clear_req  -> clear_done, busy        : full-board clear to CELL_EMPTY
//   place_req/x/y/data -> place_ack/err   : placement client
//   shot_req/x/y/data  -> shot_ack/err    : shot client
//   write_addr {y,x}, write_data, write_enable : board_mem write port
// Build option: BOARD_WRITE_ARB_CLEAR_ON_RESET_EN starts a clear sweep on the
// first clock edge after reset release.
module board_write_arb
  import warships_pkg::*;
#(
  parameter int unsigned X_SIZE = BOARD_X_SIZE,
  parameter int unsigned Y_SIZE = BOARD_Y_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  output logic                    clear_done,
  output logic                    busy,
  input  logic                    place_req,
  input  logic [COORD_W-1:0]      place_x,
  input  logic [COORD_W-1:0]      place_y,
  input  logic [1:0]              place_data,
  output logic                    place_ack,
  output logic                    place_err,
  input  logic                    shot_req,
  input  logic [COORD_W-1:0]      shot_x,
  input  logic [COORD_W-1:0]      shot_y,
  input  logic [1:0]              shot_data,
  output logic                    shot_ack,
  output logic                    shot_err,
  output logic [BOARD_ADDR_W-1:0] write_addr,
  output logic [1:0]              write_data,
  output logic                    write_enable
);

  arb_state_t              r_state,        w_state_nxt;
  grant_t                  r_last_grant,   w_last_grant_nxt;
  logic                    r_sweep_end,    w_sweep_end_nxt;
  logic [BOARD_ADDR_W-1:0] r_write_addr,   w_write_addr_nxt;
  logic [1:0]              r_write_data,   w_write_data_nxt;
  logic                    r_write_enable, w_write_enable_nxt;
  logic                    r_busy,         w_busy_nxt;
  logic                    r_clear_done,   w_clear_done_nxt;
  logic                    r_place_ack,    w_place_ack_nxt;
  logic                    r_place_err,    w_place_err_nxt;
  logic                    r_shot_ack,     w_shot_ack_nxt;
  logic                    r_shot_err,     w_shot_err_nxt;

  logic                    w_seq_start;
  logic                    w_seq_step;
  logic                    w_seq_last;
  logic [COORD_W-1:0]      w_seq_x;
  logic [COORD_W-1:0]      w_seq_y;

  logic                    w_clear_start;
  logic                    w_place_ok;
  logic                    w_shot_ok;
  logic                    w_place_gnt;
  logic                    w_shot_gnt;
  logic                    w_place_on_grid;
  logic                    w_shot_on_grid;

  board_clear_seq #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_clear_seq (
    .clk   (clk),
    .rst   (rst),
    .start (w_seq_start),
    .step  (w_seq_step),
    .x     (w_seq_x),
    .y     (w_seq_y),
    .last  (w_seq_last)
  );

`ifdef BOARD_WRITE_ARB_CLEAR_ON_RESET_EN
  // High only until the first edge after reset; acts as a clear_req sampled there.
  logic r_boot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_boot <= 1'b1;
    end else begin
      r_boot <= 1'b0;
    end
  end

  assign w_clear_start = clear_req | r_boot;
`else
  assign w_clear_start = clear_req;
`endif

  // A client whose ack is high this cycle still shows its old req; skip it.
  assign w_place_ok  = place_req & ~r_place_ack;
  assign w_shot_ok   = shot_req  & ~r_shot_ack;
  assign w_place_gnt = w_place_ok & (~w_shot_ok | (r_last_grant == GNT_SHOT));
  assign w_shot_gnt  = w_shot_ok  & ~w_place_gnt;

  assign w_place_on_grid = coord_on_grid(place_x, place_y, X_SIZE, Y_SIZE);
  assign w_shot_on_grid  = coord_on_grid(shot_x,  shot_y,  X_SIZE, Y_SIZE);

  always_comb begin
    w_state_nxt        = r_state;
    w_last_grant_nxt   = r_last_grant;
    w_sweep_end_nxt    = r_sweep_end;
    w_write_addr_nxt   = r_write_addr;
    w_write_data_nxt   = r_write_data;
    w_write_enable_nxt = 1'b0;
    w_busy_nxt         = 1'b0;
    w_clear_done_nxt   = 1'b0;
    w_place_ack_nxt    = 1'b0;
    w_place_err_nxt    = 1'b0;
    w_shot_ack_nxt     = 1'b0;
    w_shot_err_nxt     = 1'b0;
    w_seq_start        = 1'b0;
    w_seq_step         = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_clear_start) begin
          // The counter rests at (0,0) in IDLE, so the first clear write
          // leaves on the same edge that enters CLEAR.
          w_state_nxt        = ARB_CLEAR;
          w_write_enable_nxt = 1'b1;
          w_write_addr_nxt   = {w_seq_y, w_seq_x};
          w_write_data_nxt   = CELL_EMPTY;
          w_busy_nxt         = 1'b1;
          w_seq_step         = 1'b1;
          w_sweep_end_nxt    = w_seq_last;
        end else if (w_place_gnt) begin
          w_last_grant_nxt = GNT_PLACE;
          w_place_ack_nxt  = 1'b1;
          w_place_err_nxt  = ~w_place_on_grid;
          if (w_place_on_grid) begin
            w_write_enable_nxt = 1'b1;
            w_write_addr_nxt   = {place_y, place_x};
            w_write_data_nxt   = place_data;
          end
        end else if (w_shot_gnt) begin
          w_last_grant_nxt = GNT_SHOT;
          w_shot_ack_nxt   = 1'b1;
          w_shot_err_nxt   = ~w_shot_on_grid;
          if (w_shot_on_grid) begin
            w_write_enable_nxt = 1'b1;
            w_write_addr_nxt   = {shot_y, shot_x};
            w_write_data_nxt   = shot_data;
          end
        end
      end

      ARB_CLEAR: begin
        // r_sweep_end marks that the final cell has already been issued, so
        // the state stays CLEAR for exactly as many cycles as busy is high.
        if (r_sweep_end) begin
          w_state_nxt      = ARB_DONE;
          w_clear_done_nxt = 1'b1;
          w_seq_start      = 1'b1;
          w_sweep_end_nxt  = 1'b0;
        end else begin
          w_write_enable_nxt = 1'b1;
          w_write_addr_nxt   = {w_seq_y, w_seq_x};
          w_write_data_nxt   = CELL_EMPTY;
          w_busy_nxt         = 1'b1;
          w_seq_step         = 1'b1;
          w_sweep_end_nxt    = w_seq_last;
        end
      end

      ARB_DONE: begin
        w_state_nxt = ARB_IDLE;
      end

      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ARB_IDLE;
      r_last_grant   <= GNT_SHOT;
      r_sweep_end    <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
      r_busy         <= 1'b0;
      r_clear_done   <= 1'b0;
      r_place_ack    <= 1'b0;
      r_place_err    <= 1'b0;
      r_shot_ack     <= 1'b0;
      r_shot_err     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_sweep_end    <= w_sweep_end_nxt;
      r_write_addr   <= w_write_addr_nxt;
      r_write_data   <= w_write_data_nxt;
      r_write_enable <= w_write_enable_nxt;
      r_busy         <= w_busy_nxt;
      r_clear_done   <= w_clear_done_nxt;
      r_place_ack    <= w_place_ack_nxt;
      r_place_err    <= w_place_err_nxt;
      r_shot_ack     <= w_shot_ack_nxt;
      r_shot_err     <= w_shot_err_nxt;
    end
  end

  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;
  assign busy         = r_busy;
  assign clear_done   = r_clear_done;
  assign place_ack    = r_place_ack;
  assign place_err    = r_place_err;
  assign shot_ack     = r_shot_ack;
  assign shot_err     = r_shot_err;

endmodule

// File: tb/tb_board_write_arb.sv
// tb_board_write_arb: self-checking bench for board_write_arb.
// Expected write/ack events (with their cycle) are queued as stimulus is
// driven; a negedge monitor pops and compares every DUT write or ack.
module tb_board_write_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       clear_done;
  logic       busy;
  logic       place_req;
  logic [3:0] place_x;
  logic [3:0] place_y;
  logic [1:0] place_data;
  logic       place_ack;
  logic       place_err;
  logic       shot_req;
  logic [3:0] shot_x;
  logic [3:0] shot_y;
  logic [1:0] shot_data;
  logic       shot_ack;
  logic       shot_err;
  logic [7:0] write_addr;
  logic [1:0] write_data;
  logic       write_enable;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] addr;
    logic [1:0] data;
    logic       pa;
    logic       pe;
    logic       sa;
    logic       se;
  } exp_t;

  exp_t q[$];

  board_write_arb #(
    .X_SIZE (12),
    .Y_SIZE (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .clear_done   (clear_done),
    .busy         (busy),
    .place_req    (place_req),
    .place_x      (place_x),
    .place_y      (place_y),
    .place_data   (place_data),
    .place_ack    (place_ack),
    .place_err    (place_err),
    .shot_req     (shot_req),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .shot_data    (shot_data),
    .shot_ack     (shot_ack),
    .shot_err     (shot_err),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (write_enable || place_ack || shot_ack) begin
      total_cnt++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d we=%b addr=%h data=%h pa=%b sa=%b, expected no event",
                 cyc, write_enable, write_addr, write_data, place_ack, shot_ack);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc !== e.cyc || write_enable !== e.we || place_ack !== e.pa || place_err !== e.pe ||
            shot_ack !== e.sa || shot_err !== e.se ||
            (e.we && (write_addr !== e.addr || write_data !== e.data))) begin
          $display("FAIL scoreboard got cyc=%0d we=%b addr=%h data=%h pa=%b pe=%b sa=%b se=%b, expected cyc=%0d we=%b addr=%h data=%h pa=%b pe=%b sa=%b se=%b",
                   cyc, write_enable, write_addr, write_data, place_ack, place_err, shot_ack, shot_err,
                   e.cyc, e.we, e.addr, e.data, e.pa, e.pe, e.sa, e.se);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic we, input logic [7:0] a, input logic [1:0] d,
                          input logic pa, input logic pe, input logic sa, input logic se);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d;
    e.pa = pa; e.pe = pe; e.sa = sa; e.se = se;
    q.push_back(e);
  endtask

  // Clear request sampled on the edge after cycle 'base': write i lands at base+1+i.
  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] xx;
      logic [3:0] yy;
      xx = 4'(i % 12);
      yy = 4'(i / 12);
      push_exp(base + 1 + i, 1'b1, {yy, xx}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Waits for clear_done (bounded); returns the cycle seen or -1 on timeout.
  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if (clear_done) done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    int r0;
    int dc;
    rst = 1'b0; clear_req = 1'b0;
    place_req = 1'b0; place_x = '0; place_y = '0; place_data = '0;
    shot_req  = 1'b0; shot_x  = '0; shot_y  = '0; shot_data  = '0;
    repeat (3) @(negedge clk);
    obs = {write_addr, write_data, write_enable, busy, clear_done, place_ack, place_err, shot_ack, shot_err};
    total_cnt++;
    if (obs !== 17'h0) $display("FAIL reset_outputs got %h expected 0", obs);
    else pass_cnt++;
    rst = 1'b1;
    r0 = cyc;
`ifdef BOARD_WRITE_ARB_CLEAR_ON_RESET_EN
    push_clear(r0, 144);
    wait_done(dc);
    total_cnt++;
    if (dc !== r0 + 145) $display("FAIL reset_autoclear_done got cyc %0d expected %0d", dc, r0 + 145);
    else pass_cnt++;
`else
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b expected 0", busy);
    else pass_cnt++;
`endif
  endtask

  task automatic test_clear();
    int c0;
    int busy_n = 0;
    int dc = -1;
    logic busy_at_done = 1'bx;
    @(negedge clk);
    c0 = cyc;
    clear_req = 1'b1;
    push_clear(c0, 144);
    for (int k = 0; k < 300 && dc < 0; k++) begin
      @(negedge clk);
      clear_req = (cyc == c0 + 100);   // mid-sweep re-request, must be ignored
      if (busy) busy_n++;
      if (clear_done) begin
        dc = cyc;
        busy_at_done = busy;
        clear_req = 1'b1;              // sampled in DONE, must be ignored
      end
    end
    @(negedge clk);
    clear_req = 1'b0;
    total_cnt++;
    if (dc !== c0 + 145) $display("FAIL clear_done_cycle got %0d expected %0d", dc, c0 + 145);
    else pass_cnt++;
    total_cnt++;
    if (busy_n !== 144) $display("FAIL clear_busy_cycles got %0d expected 144", busy_n);
    else pass_cnt++;
    total_cnt++;
    if (busy_at_done !== 1'b0) $display("FAIL clear_busy_at_done got %b expected 0", busy_at_done);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({busy, clear_done} !== 2'b00) $display("FAIL clear_after_idle got %b expected 00", {busy, clear_done});
    else pass_cnt++;
  endtask

  task automatic test_place_single();
    int c0;
    bit seen = 0;
    @(negedge clk);
    c0 = cyc;
    place_req = 1'b1; place_x = 4'd3; place_y = 4'd5; place_data = 2'b01;
    push_exp(c0 + 1, 1'b1, 8'h53, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (place_ack) seen = 1;
    end
    total_cnt++;
    if (!seen || place_err !== 1'b0) $display("FAIL place_single_ack got seen=%0d err=%b expected seen=1 err=0", seen, place_err);
    else pass_cnt++;
    // Re-raise at once with the far corner: one write per two cycles.
    place_x = 4'd11; place_y = 4'd11; place_data = 2'b10;
    push_exp(c0 + 3, 1'b1, 8'hBB, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (place_ack !== 1'b0) $display("FAIL place_no_double_ack got %b expected 0", place_ack);
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (place_ack) seen = 1;
      else @(negedge clk);
    end
    place_req = 1'b0;
    total_cnt++;
    if (!seen) $display("FAIL place_second_ack got timeout expected ack");
    else pass_cnt++;
  endtask

  task automatic test_shot_range();
    logic [3:0] sx[3];
    logic [3:0] sy[3];
    logic       serr[3];
    sx = '{4'd12, 4'd0, 4'd11};
    sy = '{4'd0, 4'd12, 4'd0};
    serr = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      int c0;
      bit seen;
      @(negedge clk);
      c0 = cyc;
      seen = 0;
      shot_req = 1'b1; shot_x = sx[i]; shot_y = sy[i]; shot_data = 2'b11;
      push_exp(c0 + 1, !serr[i], {sy[i], sx[i]}, 2'b11, 1'b0, 1'b0, 1'b1, serr[i]);
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (shot_ack) seen = 1;
      end
      total_cnt++;
      if (!seen || shot_err !== serr[i] || write_enable !== !serr[i])
        $display("FAIL shot_range_%0d got seen=%0d err=%b we=%b expected err=%b we=%b",
                 i, seen, shot_err, write_enable, serr[i], !serr[i]);
      else pass_cnt++;
      shot_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int pi = 0;
    int si = 0;
    int both = 0;
    @(negedge clk);
    c0 = cyc;
    place_req = 1'b1; place_x = 4'd0;  place_y = 4'd1; place_data = 2'b01;
    shot_req  = 1'b1; shot_x  = 4'd11; shot_y  = 4'd2; shot_data  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] px;
      logic [3:0] py;
      logic [3:0] sxx;
      px = 4'(i); py = 4'(i + 1); sxx = 4'(11 - i);
      push_exp(c0 + 1 + 2 * i, 1'b1, {py, px}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      push_exp(c0 + 2 + 2 * i, 1'b1, {4'd2, sxx}, (i % 2 == 0) ? 2'b11 : 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 40 && (pi < 4 || si < 4); k++) begin
      @(negedge clk);
      if (place_ack && shot_ack) both++;
      if (place_ack) begin
        pi++;
        if (pi < 4) begin place_x = 4'(pi); place_y = 4'(pi + 1); end
        else place_req = 1'b0;
      end
      if (shot_ack) begin
        si++;
        if (si < 4) begin shot_x = 4'(11 - si); shot_data = (si % 2 == 0) ? 2'b11 : 2'b10; end
        else shot_req = 1'b0;
      end
    end
    place_req = 1'b0; shot_req = 1'b0;
    total_cnt++;
    if (pi !== 4 || si !== 4 || both !== 0)
      $display("FAIL back_to_back_counts got place=%0d shot=%0d both=%0d expected 4 4 0", pi, si, both);
    else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    int c0;
    int ack_cyc = -1;
    @(negedge clk);
    c0 = cyc;
    clear_req = 1'b1;
    place_req = 1'b1; place_x = 4'd4; place_y = 4'd7; place_data = 2'b11;
    push_clear(c0, 144);
    push_exp(c0 + 147, 1'b1, 8'h74, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300 && ack_cyc < 0; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if (place_ack) ack_cyc = cyc;
    end
    place_req = 1'b0;
    total_cnt++;
    if (ack_cyc !== c0 + 147) $display("FAIL clear_priority_grant got cyc %0d expected %0d", ack_cyc, c0 + 147);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int c0;
    int r0;
    int dc;
    logic [16:0] obs;
    @(negedge clk);
    c0 = cyc;
    clear_req = 1'b1;
    push_clear(c0, 50);
    for (int k = 0; k < 100 && cyc < c0 + 50; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    obs = {write_addr, write_data, write_enable, busy, clear_done, place_ack, place_err, shot_ack, shot_err};
    total_cnt++;
    if (obs !== 17'h0) $display("FAIL midsweep_reset_outputs got %h expected 0", obs);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    r0 = cyc;
`ifdef BOARD_WRITE_ARB_CLEAR_ON_RESET_EN
    push_clear(r0, 144);
    wait_done(dc);
    total_cnt++;
    if (dc !== r0 + 145) $display("FAIL midsweep_restart_done got cyc %0d expected %0d", dc, r0 + 145);
    else pass_cnt++;
`else
    repeat (20) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midsweep_idle_busy got %b expected 0", busy);
    else pass_cnt++;
    // A new sweep must begin again at (0,0).
    @(negedge clk);
    r0 = cyc;
    clear_req = 1'b1;
    push_clear(r0, 144);
    wait_done(dc);
    total_cnt++;
    if (dc !== r0 + 145) $display("FAIL midsweep_fresh_done got cyc %0d expected %0d", dc, r0 + 145);
    else pass_cnt++;
`endif
  endtask

  task automatic test_drain();
    repeat (5) @(negedge clk);
    total_cnt++;
    if (q.size() !== 0) $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_place_single();
    test_shot_range();
    test_back_to_back();
    test_clear_priority();
    test_reset_mid_sweep();
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
